// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE_INST,
    ST_SERVE_DATA,
    ST_DONE_INST,
    ST_DONE_DATA
  } arb_state_e;

  typedef enum logic {
    GNT_INST,
    GNT_DATA
  } arb_gnt_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned WD_CNT_W  = 8;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Loadable down-counter; expire_o flags the last permitted wait cycle.
module mem_arb_watchdog
  import mem_arb_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [WD_CNT_W-1:0] load_val_i,
  input  logic                dec_i,
  output logic                expire_o
);

  logic [WD_CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A decrement taken while at 1 is the one that reaches zero.
  assign expire_o = (count_q == WD_CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store requests onto one single-ported memory,
// alternating priority on contention and aborting hung accesses via a watchdog.
//   state      | meaning
//   IDLE       | no access in flight, pick next requester
//   SERVE_INST | fetch strobe on memory, waiting READY
//   SERVE_DATA | load/store strobe on memory, waiting READY
//   DONE_INST  | fetch result presented, INST stall released
//   DONE_DATA  | data result presented, DATA stall released
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inst_read_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_readdata_o,
  output logic        inst_busywait_o,
  input  logic        data_read_i,
  input  logic        data_write_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_writedata_i,
  output logic [31:0] data_readdata_o,
  output logic        data_busywait_o,
  output logic        main_mem_read_o,
  output logic        main_mem_write_o,
  output logic [31:0] main_mem_addr_o,
  output logic [31:0] main_mem_writedata_o,
  input  logic [31:0] main_mem_readdata_i,
  input  logic        main_mem_ready_i,
  output logic        arb_timeout_o
);

  arb_state_e  state_q, state_d;
  arb_gnt_e    last_gnt_q, last_gnt_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        timeout_q, timeout_d;
  logic        wd_load, wd_dec, wd_expire;
  logic        inst_req, data_req;

  assign inst_req = inst_read_i;
  assign data_req = data_read_i | data_write_i;

  mem_arb_watchdog u_watchdog (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (wd_load),
    .load_val_i (WD_CNT_W'(TIMEOUT_CYCLES)),
    .dec_i      (wd_dec),
    .expire_o   (wd_expire)
  );

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    timeout_d    = timeout_q;
    wd_load      = 1'b0;
    wd_dec       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (inst_req && (!data_req || (last_gnt_q == GNT_DATA))) begin
          state_d     = ST_SERVE_INST;
          last_gnt_d  = GNT_INST;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = inst_addr_i;
          mem_wdata_d = '0;
          wd_load     = 1'b1;
        end else if (data_req) begin
          state_d     = ST_SERVE_DATA;
          last_gnt_d  = GNT_DATA;
          mem_read_d  = data_read_i;
          mem_write_d = data_write_i;
          mem_addr_d  = data_addr_i;
          mem_wdata_d = data_writedata_i;
          wd_load     = 1'b1;
        end
      end
      ST_SERVE_INST: begin
        if (main_mem_ready_i) begin
          inst_rdata_d = main_mem_readdata_i;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          state_d      = ST_DONE_INST;
        end else begin
          wd_dec = 1'b1;
          if (wd_expire) begin
            timeout_d    = 1'b1;
            inst_rdata_d = NOP_INSTR;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            state_d      = ST_DONE_INST;
          end
        end
      end
      ST_SERVE_DATA: begin
        if (main_mem_ready_i) begin
          if (mem_read_q) data_rdata_d = main_mem_readdata_i;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_DONE_DATA;
        end else begin
          wd_dec = 1'b1;
          if (wd_expire) begin
            timeout_d = 1'b1;
            if (mem_read_q) data_rdata_d = '0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            state_d     = ST_DONE_DATA;
          end
        end
      end
      ST_DONE_INST, ST_DONE_DATA: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      last_gnt_q   <= GNT_DATA;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      timeout_q    <= timeout_d;
    end
  end

  // Stall is released only in the requester's DONE cycle; a flushed request sees no stall.
  assign inst_busywait_o      = inst_req && (state_q != ST_DONE_INST);
  assign data_busywait_o      = data_req && (state_q != ST_DONE_DATA);
  assign inst_readdata_o      = inst_rdata_q;
  assign data_readdata_o      = data_rdata_q;
  assign main_mem_read_o      = mem_read_q;
  assign main_mem_write_o     = mem_write_q;
  assign main_mem_addr_o      = mem_addr_q;
  assign main_mem_writedata_o = mem_wdata_q;
  assign arb_timeout_o        = timeout_q;

endmodule
